// File: rtl/pcpi_issue_ctrl.sv
// PCPI initiator: takes one custom instruction per request, waits for the coprocessor, times out unclaimed work.
// Optional PCPI_ISSUE_LATENCY_EN adds lat_cycles (ISSUE cycles of the last completed instruction).
module pcpi_issue_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_wr,
`ifdef PCPI_ISSUE_LATENCY_EN
    output logic [15:0] lat_cycles,
`endif
    output logic        rsp_trap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // The count value seen in the TIMEOUT-th idle ISSUE cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_insn;
    logic [31:0]      r_rs1;
    logic [31:0]      r_rs2;
    logic [31:0]      r_rd;
    logic             r_wr;
    logic             r_trap;
    logic             w_timeout;

    assign w_timeout = !pcpi_ready && !pcpi_wait && (r_cnt == TO_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_next = ISSUE;
            ISSUE:   if (pcpi_ready || w_timeout) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_insn <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_wr   <= 1'b0;
            r_trap <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_insn <= req_insn;
                        r_rs1  <= req_rs1;
                        r_rs2  <= req_rs2;
                        r_cnt  <= '0;
                    end
                end
                ISSUE: begin
                    if (pcpi_ready) begin
                        r_rd   <= pcpi_rd;
                        r_wr   <= pcpi_wr;
                        r_trap <= 1'b0;
                    end else if (pcpi_wait) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_timeout) begin
                            r_rd   <= '0;
                            r_wr   <= 1'b0;
                            r_trap <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PCPI_ISSUE_LATENCY_EN
    logic [15:0] r_lat_run;
    logic [15:0] r_lat_cycles;
    logic [15:0] w_lat_inc;

    assign w_lat_inc = (r_lat_run == 16'hFFFF) ? r_lat_run : r_lat_run + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_run    <= '0;
            r_lat_cycles <= '0;
        end else if (r_state == IDLE && req_valid) begin
            r_lat_run <= '0;
        end else if (r_state == ISSUE) begin
            r_lat_run <= w_lat_inc;
            if (w_state_next == RESP) r_lat_cycles <= w_lat_inc;
        end
    end

    assign lat_cycles = r_lat_cycles;
`endif

    assign req_ready  = (r_state == IDLE);
    assign pcpi_valid = (r_state == ISSUE);
    assign rsp_valid  = (r_state == RESP);
    assign pcpi_insn  = r_insn;
    assign pcpi_rs1   = r_rs1;
    assign pcpi_rs2   = r_rs2;
    assign rsp_rd     = r_rd;
    assign rsp_wr     = r_wr;
    assign rsp_trap   = r_trap;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Directed bench for pcpi_issue_ctrl: a stub coprocessor driven from the initial block, one line per transaction.
module tb_pcpi_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_wr;
    logic        rsp_trap;
`ifdef PCPI_ISSUE_LATENCY_EN
    logic [15:0] lat_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pcpi_issue_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rd     (rsp_rd),
        .rsp_wr     (rsp_wr),
`ifdef PCPI_ISSUE_LATENCY_EN
        .lat_cycles (lat_cycles),
`endif
        .rsp_trap   (rsp_trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    localparam logic [31:0] INSN_A = 32'b0000101_00001_00010_001_00011_0110011;

    initial begin
        int  n;
        logic ok;

        rst = 1'b1; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        chk("rst_pcpi_valid", 32'(pcpi_valid), 32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
        chk("rst_pcpi_insn",  pcpi_insn, 32'd0);
        chk("rst_rsp_rd",     rsp_rd, 32'd0);
        rst = 1'b0;
        tick();

        // Fast responder: ready in the first ISSUE cycle.
        issue(INSN_A, 32'hbadca77e, 32'h0ca7100f);
        chk("fast_pcpi_valid", 32'(pcpi_valid), 32'd1);
        chk("fast_req_ready",  32'(req_ready), 32'd0);
        chk("fast_insn",       pcpi_insn, INSN_A);
        chk("fast_rs1",        pcpi_rs1, 32'hbadca77e);
        chk("fast_rs2",        pcpi_rs2, 32'h0ca7100f);
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h143faf8a;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("fast_rsp_valid",  32'(rsp_valid), 32'd1);
        chk("fast_pcpi_off",   32'(pcpi_valid), 32'd0);
        chk("fast_rsp_rd",     rsp_rd, 32'h143faf8a);
        chk("fast_rsp_wr",     32'(rsp_wr), 32'd1);
        chk("fast_rsp_trap",   32'(rsp_trap), 32'd0);
`ifdef PCPI_ISSUE_LATENCY_EN
        chk("fast_lat",        32'(lat_cycles), 32'd1);
`endif
        drain();
        $display("txn fast: rd=%h wr=%0d trap=%0d", 32'h143faf8a, 1, 0);

        // Multi-cycle responder: 40 wait cycles then ready.
        issue(32'h0000_100b, 32'h1111_2222, 32'h3333_4444);
        pcpi_wait = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!pcpi_valid || pcpi_insn !== 32'h0000_100b || pcpi_rs1 !== 32'h1111_2222
                || pcpi_rs2 !== 32'h3333_4444 || rsp_valid) ok = 1'b0;
        end
        chk("wait_stable", 32'(ok), 32'd1);
        pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_rd = 32'h12345678; pcpi_wr = 1'b0;
        tick();
        pcpi_ready = 1'b0;
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wait_rsp_rd",    rsp_rd, 32'h12345678);
        chk("wait_rsp_wr",    32'(rsp_wr), 32'd0);
        chk("wait_rsp_trap",  32'(rsp_trap), 32'd0);
`ifdef PCPI_ISSUE_LATENCY_EN
        chk("wait_lat",       32'(lat_cycles), 32'd41);
`endif
        drain();
        $display("txn wait: rd=%h trap=0", 32'h12345678);

        // No responder; a stray pcpi_wr without ready must not leak into rsp_wr.
        issue(32'h0000_200b, 32'h5, 32'h6);
        pcpi_wr = 1'b1; pcpi_rd = 32'hffff_ffff;
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        pcpi_wr = 1'b0;
        chk("to_cycles",   32'(n), 32'd16);
        chk("to_rsp_trap", 32'(rsp_trap), 32'd1);
        chk("to_rsp_rd",   rsp_rd, 32'd0);
        chk("to_rsp_wr",   32'(rsp_wr), 32'd0);
`ifdef PCPI_ISSUE_LATENCY_EN
        chk("to_lat",      32'(lat_cycles), 32'd16);
`endif
        drain();
        $display("txn timeout: cycles=%0d trap=1", n);

        // Ready arrives in the 16th ISSUE cycle, same cycle the timeout would fire.
        issue(32'h0000_300b, 32'h7, 32'h8);
        for (int i = 0; i < 15; i++) tick();
        chk("race_pending", 32'(rsp_valid), 32'd0);
        pcpi_ready = 1'b1; pcpi_rd = 32'ha5a5_5a5a; pcpi_wr = 1'b1;
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0;
        chk("race_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("race_rsp_trap",  32'(rsp_trap), 32'd0);
        chk("race_rsp_rd",    rsp_rd, 32'ha5a5_5a5a);
        chk("race_rsp_wr",    32'(rsp_wr), 32'd1);
        drain();
        $display("txn race: rd=%h trap=0", 32'ha5a55a5a);

        // Backpressure: response held while late ready pulses and a new request are ignored.
        issue(32'h0000_400b, 32'h9, 32'ha);
        pcpi_ready = 1'b1; pcpi_rd = 32'hcafe_f00d; pcpi_wr = 1'b1;
        tick();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pcpi_ready = i[0]; pcpi_rd = 32'hdead_beef; pcpi_wr = 1'b0;
            req_valid = 1'b1;
            tick();
            if (!rsp_valid || rsp_rd !== 32'hcafe_f00d || !rsp_wr || rsp_trap
                || req_ready || pcpi_valid) ok = 1'b0;
        end
        pcpi_ready = 1'b0; req_valid = 1'b0;
        chk("bp_held", 32'(ok), 32'd1);
        drain();
        chk("bp_req_ready", 32'(req_ready), 32'd1);
        chk("bp_rsp_off",   32'(rsp_valid), 32'd0);
        $display("txn backpressure: rd=%h held 5 cycles", 32'hcafef00d);

        // Reset in the middle of ISSUE.
        issue(32'h0000_500b, 32'hb, 32'hc);
        tick(); tick();
        chk("rst_mid_valid", 32'(pcpi_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_pcpi", 32'(pcpi_valid), 32'd0);
        chk("rst_async_rsp",  32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("rst_after_ready", 32'(req_ready), 32'd1);
        chk("rst_after_rsp",   32'(rsp_valid), 32'd0);
        chk("rst_after_rd",    rsp_rd, 32'd0);
`ifdef PCPI_ISSUE_LATENCY_EN
        chk("rst_after_lat",   32'(lat_cycles), 32'd0);
`endif
        $display("txn reset: in-flight instruction discarded");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
